// File: rtl/simon_seq_player.sv
// Simon Says sequence store and playback: appends one LFSR-derived colour
// per round, then replays the whole sequence on four one-hot LEDs.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   lfsr_val      current LFSR output; colour = val[1:0] ^ val[7:6]
//   lfsr_valid    lfsr_val usable this cycle (only looked at in APPEND)
//   start_round   pulse: append a colour (unless full) then replay
//   clear         synchronous: drop the sequence and return to IDLE
//   rd_idx        checker read index
//   rd_color      stored colour at rd_idx (combinational)
//   led           registered one-hot colour, 0 = dark
//   playing       high in APPEND, ON and OFF
//   done          one-cycle pulse when playback ends
//   seq_len       number of stored colours
//   full          seq_len == MAX_LEN
module simon_seq_player #(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     lfsr_val,
    input  logic                           lfsr_valid,
    input  logic                           start_round,
    input  logic                           clear,
    input  logic [$clog2(MAX_LEN)-1:0]     rd_idx,
    output logic [1:0]                     rd_color,
    output logic [3:0]                     led,
    output logic                           playing,
    output logic                           done,
    output logic [$clog2(MAX_LEN+1)-1:0]   seq_len,
    output logic                           full
);

    localparam int IW   = $clog2(MAX_LEN);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int CMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   seq_len_q, seq_len_d;
    logic [3:0]      led_q, led_d;
    logic [1:0]      mem_q [MAX_LEN];

    logic            we;
    logic [IW-1:0]   wr_idx;
    logic [1:0]      new_color;
    logic [1:0]      col_nxt;
    logic            full_w;
    logic            last_w;
    logic            unused_lfsr;

    assign new_color   = lfsr_val[1:0] ^ lfsr_val[7:6];
    assign unused_lfsr = ^lfsr_val[5:2];
    assign wr_idx      = IW'(seq_len_q);
    assign full_w      = (seq_len_q == LW'(MAX_LEN));
    assign last_w      = (LW'(idx_q) == (seq_len_q - LW'(1)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        seq_len_d = seq_len_q;
        we        = 1'b0;
        if (clear) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            seq_len_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_round) begin
                        if (!full_w) begin
                            state_d = S_APPEND;
                        end else begin
                            state_d = S_ON;
                            idx_d   = '0;
                            cnt_d   = ON_LOAD;
                        end
                    end
                end
                S_APPEND: begin
                    if (lfsr_valid) begin
                        we        = 1'b1;
                        seq_len_d = seq_len_q + LW'(1);
                        idx_d     = '0;
                        cnt_d     = ON_LOAD;
                        state_d   = S_ON;
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        state_d = S_OFF;
                        cnt_d   = OFF_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_OFF: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (last_w) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ON;
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = ON_LOAD;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // The colour being appended this cycle is not in memory yet, so
    // bypass it when it is also the first entry to be shown.
    always_comb begin
        col_nxt = mem_q[idx_d];
        if (we && (wr_idx == idx_d)) begin
            col_nxt = new_color;
        end
        led_d = (state_d == S_ON) ? (4'b0001 << col_nxt) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            seq_len_q <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            seq_len_q <= seq_len_d;
            led_q     <= led_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= new_color;
        end
    end

    assign rd_color = mem_q[rd_idx];
    assign led      = led_q;
    assign playing  = (state_q == S_APPEND) || (state_q == S_ON)
                   || (state_q == S_OFF);
    assign done     = (state_q == S_DONE);
    assign seq_len  = seq_len_q;
    assign full     = full_w;

endmodule

// File: tb/tb_simon_seq_player.sv
// Bench for simon_seq_player: random rounds checked cycle by cycle
// against a queue-based model of the stored colour sequence.
module tb_simon_seq_player;

    localparam int ML  = 4;
    localparam int ON  = 4;
    localparam int OFF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] lfsr_val;
    logic       lfsr_valid;
    logic       start_round;
    logic       clear;
    logic [1:0] rd_idx;
    logic [1:0] rd_color;
    logic [3:0] led;
    logic       playing;
    logic       done;
    logic [2:0] seq_len;
    logic       full;

    int errs   = 0;
    int checks = 0;

    logic [1:0] q [$];

    simon_seq_player #(
        .MAX_LEN   (ML),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lfsr_val   (lfsr_val),
        .lfsr_valid (lfsr_valid),
        .start_round(start_round),
        .clear      (clear),
        .rd_idx     (rd_idx),
        .rd_color   (rd_color),
        .led        (led),
        .playing    (playing),
        .done       (done),
        .seq_len    (seq_len),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] col_of(input logic [7:0] v);
        int c;
        c = (int'(v) % 4) ^ (int'(v) / 64);
        return 2'(c);
    endfunction

    function automatic logic [3:0] lamp(input logic [1:0] c);
        return 4'(2 ** int'(c));
    endfunction

    task automatic do_round(input logic [7:0] v, input int stall);
        start_round = 1'b1;
        lfsr_valid  = 1'($urandom % 2);
        lfsr_val    = 8'($urandom);
        @(posedge clk); #1;
        start_round = 1'b0;
        if (q.size() < ML) begin
            for (int s = 0; s <= stall; s++) begin
                lfsr_valid  = (s == stall);
                lfsr_val    = (s == stall) ? v : 8'($urandom);
                start_round = (s != stall);
                @(negedge clk);
                chk("app_playing", 32'(playing), 32'd1);
                chk("app_led", 32'(led), 32'd0);
                chk("app_done", 32'(done), 32'd0);
                @(posedge clk); #1;
            end
            q.push_back(col_of(v));
        end
        start_round = 1'b0;
        lfsr_valid  = 1'b0;
        foreach (q[i]) begin
            for (int c = 0; c < ON + OFF; c++) begin
                @(negedge clk);
                chk("led", 32'(led), (c < ON) ? 32'(lamp(q[i])) : 32'd0);
                chk("playing", 32'(playing), 32'd1);
                chk("done_early", 32'(done), 32'd0);
                @(posedge clk); #1;
                start_round = 1'($urandom % 2);
                lfsr_valid  = 1'($urandom % 2);
                lfsr_val    = 8'($urandom);
            end
        end
        start_round = 1'b0;
        lfsr_valid  = 1'b0;
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("done_playing", 32'(playing), 32'd0);
        chk("done_led", 32'(led), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_playing", 32'(playing), 32'd0);
        chk("seq_len", 32'(seq_len), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == ML));
        foreach (q[i]) begin
            rd_idx = 2'(i);
            #1;
            chk("rd_color", 32'(rd_color), 32'(q[i]));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        lfsr_val    = '0;
        lfsr_valid  = 1'b0;
        start_round = 1'b0;
        clear       = 1'b0;
        rd_idx      = '0;
        @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len", 32'(seq_len), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_round(8'h01, 0);
        do_round(8'hC0, 0);
        do_round(8'h02, 3);
        rd_idx = 2'd1;
        #1;
        chk("rd_idx1", 32'(rd_color), 32'd3);
        do_round(8'($urandom), 1);
        chk("full4", 32'(full), 32'd1);
        do_round(8'($urandom), 0);
        chk("full_len", 32'(seq_len), 32'd4);

        // clear while a colour is lit
        start_round = 1'b1;
        lfsr_valid  = 1'b1;
        @(posedge clk); #1;
        start_round = 1'b0;
        lfsr_valid  = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        q.delete();
        @(negedge clk);
        chk("clr_led", 32'(led), 32'd0);
        chk("clr_playing", 32'(playing), 32'd0);
        chk("clr_len", 32'(seq_len), 32'd0);
        chk("clr_full", 32'(full), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("clr_nodone", 32'(done), 32'd0);
            chk("clr_idle", 32'(playing), 32'd0);
        end

        for (int r = 0; r < 5; r++) begin
            do_round(8'($urandom), int'($urandom_range(0, 2)));
        end

        // asynchronous reset in the middle of playback
        start_round = 1'b1;
        lfsr_valid  = 1'b1;
        @(posedge clk); #1;
        start_round = 1'b0;
        lfsr_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_playing", 32'(playing), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_len", 32'(seq_len), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_round(8'($urandom), 2);
        do_round(8'($urandom), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
